// File: rtl/isa_pkg.sv
// Shared ISA definitions for the program loader and instruction encoder.
// Contents: opcode nibbles, symbolic op enum, loader FSM states, HALT word.
package isa_pkg;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  typedef enum logic [2:0] {
    NOOP  = 3'd0,
    STORE = 3'd1,
    LOAD  = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    HALT  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE
  } loader_state_t;

  localparam logic [15:0] HALT_WORD = {OP_HALT, 12'h000};

endpackage

// File: rtl/instr_encoder.sv
// Combinational encoder: symbolic instruction fields -> 16-bit instruction word.
// Ports:
//   op      3-bit symbolic opcode (6 and 7 are illegal)
//   ra/rb/rd register fields, daddr data memory address
//   word    encoded instruction (illegal ops encode as NOOP)
//   illegal high when op is not a defined opcode
module instr_encoder
  import isa_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [3:0]  rd,
  input  logic [7:0]  daddr,
  output logic [15:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      NOOP:    word = {OP_NOOP, 12'h000};
      STORE:   word = {OP_STORE, ra, daddr};
      LOAD:    word = {OP_LOAD, daddr, rd};
      ADD:     word = {OP_ADD, ra, rb, rd};
      SUB:     word = {OP_SUB, ra, rb, rd};
      HALT:    word = HALT_WORD;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: accepts symbolic instructions over valid/ready, encodes
// them and writes them sequentially into instruction memory from address 0,
// holding the processor in Init until a HALT has been written.
// Ports:
//   clk, Reset          clock / async active-high reset
//   start               begins a session (honoured in IDLE or DONE)
//   in_valid/in_ready   host handshake; in_op/in_ra/in_rb/in_rd/in_daddr fields
//   im_wr/im_addr/im_wdata  registered instruction memory write port
//   cpu_hold            holds the controller in Init
//   done                session complete
//   overflow, bad_op    sticky status flags
//   word_count          words written this session
module prog_loader
  import isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [3:0]        in_ra,
  input  logic [3:0]        in_rb,
  input  logic [3:0]        in_rd,
  input  logic [7:0]        in_daddr,
  output logic              im_wr,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow,
  output logic              bad_op,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned        DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]    FULL    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0]  PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]    CNT_ONE = (ADDR_W + 1)'(1);

  loader_state_t     state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic              halt_r;
  logic              at_last;
  logic              hs;
  logic [15:0]       enc_word;
  logic              enc_illegal;

  instr_encoder u_enc (
    .op      (in_op),
    .ra      (in_ra),
    .rb      (in_rb),
    .rd      (in_rd),
    .daddr   (in_daddr),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    at_last  = (ptr == '1);
    hs       = in_valid && in_ready;
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = ACCEPT;
      // The last slot is reserved for HALT, so reaching it forces a write.
      ACCEPT:     if (at_last || hs) state_nx = WRITE;
      WRITE:      state_nx = halt_r ? DONE : ACCEPT;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ACCEPT) && !at_last;
    cpu_hold = (state != DONE);
    done     = (state == DONE);
  end

  // Write port is loaded on the handshake so that im_wr/im_addr/im_wdata are
  // already registered and valid throughout the WRITE cycle.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      ptr        <= '0;
      word_count <= '0;
      im_wr      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      halt_r     <= 1'b0;
      overflow   <= 1'b0;
      bad_op     <= 1'b0;
    end else begin
      im_wr <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ptr        <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            bad_op     <= 1'b0;
          end
        end
        ACCEPT: begin
          if (at_last) begin
            im_wr    <= 1'b1;
            im_addr  <= ptr;
            im_wdata <= HALT_WORD;
            halt_r   <= 1'b1;
            overflow <= 1'b1;
          end else if (hs) begin
            im_wr    <= 1'b1;
            im_addr  <= ptr;
            im_wdata <= enc_word;
            halt_r   <= (in_op == HALT);
            if (enc_illegal) bad_op <= 1'b1;
          end
        end
        WRITE: begin
          ptr <= ptr + PTR_ONE;
          if (word_count != FULL) word_count <= word_count + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset, start, in_valid, in_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_ra, in_rb, in_rd;
  logic [7:0]  in_daddr;
  logic        im_wr, cpu_hold, done, overflow, bad_op;
  logic [6:0]  im_addr;
  logic [15:0] im_wdata;
  logic [7:0]  word_count;

  logic        s_start, s_in_valid, s_in_ready;
  logic        s_im_wr, s_cpu_hold, s_done, s_overflow, s_bad_op;
  logic [2:0]  s_im_addr;
  logic [15:0] s_im_wdata;
  logic [3:0]  s_word_count;

  prog_loader #(.ADDR_W(7)) dut (
    .clk(clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .in_daddr(in_daddr),
    .im_wr(im_wr), .im_addr(im_addr), .im_wdata(im_wdata), .cpu_hold(cpu_hold),
    .done(done), .overflow(overflow), .bad_op(bad_op), .word_count(word_count)
  );

  prog_loader #(.ADDR_W(3)) dut_s (
    .clk(clk), .Reset(Reset), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .in_daddr(in_daddr),
    .im_wr(s_im_wr), .im_addr(s_im_addr), .im_wdata(s_im_wdata), .cpu_hold(s_cpu_hold),
    .done(s_done), .overflow(s_overflow), .bad_op(s_bad_op), .word_count(s_word_count)
  );

  int nvec = 0;
  int nerr = 0;

  int          wa_q[$];
  logic [15:0] wd_q[$];
  int          swa_q[$];
  logic [15:0] swd_q[$];

  always @(posedge clk) begin
    if (im_wr === 1'b1)   begin wa_q.push_back(int'(im_addr));    wd_q.push_back(im_wdata);    end
    if (s_im_wr === 1'b1) begin swa_q.push_back(int'(s_im_addr)); swd_q.push_back(s_im_wdata); end
  end

  function automatic logic [15:0] ref_word(input int op, input int ra, input int rb,
                                           input int rd, input int daddr);
    case (op)
      1:       return 16'(32'h1000 + ra * 256 + daddr);
      2:       return 16'(32'h2000 + daddr * 16 + rd);
      3:       return 16'(32'h3000 + ra * 256 + rb * 16 + rd);
      4:       return 16'(32'h4000 + ra * 256 + rb * 16 + rd);
      5:       return 16'h5000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int op, input int ra, input int rb, input int rd, input int daddr);
    in_op = 3'(op); in_ra = 4'(ra); in_rb = 4'(rb); in_rd = 4'(rd); in_daddr = 8'(daddr);
  endtask

  // Presents one instruction and returns one cycle after the handshake edge.
  task automatic send(input int op, input int ra, input int rb, input int rd, input int daddr,
                      output bit ok);
    bit rdy;
    set_fields(op, ra, rb, rd, daddr);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      rdy = in_ready;
      tick();
      if (rdy) ok = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic s_send(input int op, input int ra, input int rb, input int rd, input int daddr,
                        output bit ok);
    bit rdy;
    set_fields(op, ra, rb, rd, daddr);
    s_in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      rdy = s_in_ready;
      tick();
      if (rdy) ok = 1'b1;
    end
    s_in_valid = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    bit ok;
    Reset = 1'b1; start = 1'b0; in_valid = 1'b0; s_start = 1'b0; s_in_valid = 1'b0;
    set_fields(0, 0, 0, 0, 0);
    tick(); tick();
    nvec++; if (cpu_hold !== 1'b1) begin nerr++; $display("FAIL rst_cpu_hold got=%b exp=1", cpu_hold); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done got=%b exp=0", done); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    nvec++; if (im_wr !== 1'b0 || im_addr !== 7'd0 || im_wdata !== 16'h0) begin nerr++; $display("FAIL rst_im got=%b/%h/%h exp=0/00/0000", im_wr, im_addr, im_wdata); end
    nvec++; if (word_count !== 8'd0 || overflow !== 1'b0 || bad_op !== 1'b0) begin nerr++; $display("FAIL rst_status got=%0d/%b/%b exp=0/0/0", word_count, overflow, bad_op); end
    Reset = 1'b0;
    tick();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      send(3, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 0, ok);
      nvec++; if (!ok) begin nerr++; $display("FAIL rst_pre_send%0d timeout got=0 exp=1", i); end
      tick();
    end
    nvec++; if (word_count !== 8'd3 || in_ready !== 1'b1) begin nerr++; $display("FAIL rst_pre_state got=%0d/%b exp=3/1", word_count, in_ready); end
    #2 Reset = 1'b1;
    #1;
    nvec++; if (cpu_hold !== 1'b1 || in_ready !== 1'b0 || im_wr !== 1'b0) begin nerr++; $display("FAIL rst_async got=%b/%b/%b exp=1/0/0", cpu_hold, in_ready, im_wr); end
    tick();
    Reset = 1'b0;
    tick();
    nvec++; if (word_count !== 8'd0 || in_ready !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1) begin nerr++; $display("FAIL rst_idle got=%0d/%b/%b/%b exp=0/0/0/1", word_count, in_ready, done, cpu_hold); end
    in_valid = 1'b1;
    tick();
    nvec++; if (im_wr !== 1'b0 || in_ready !== 1'b0) begin nerr++; $display("FAIL idle_ignores_valid got=%b/%b exp=0/0", im_wr, in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_directed;
    int          t_op[5] = '{3, 4, 2, 1, 5};
    int          t_ra[5] = '{5, 1, 0, 10, 0};
    int          t_rb[5] = '{3, 2, 0, 0, 0};
    int          t_rd[5] = '{6, 5, 10, 0, 0};
    int          t_da[5] = '{0, 0, 'h6A, 'h6A, 0};
    logic [15:0] t_w[5]  = '{16'h3536, 16'h4125, 16'h26AA, 16'h1A6A, 16'h5000};
    bit ok;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      send(t_op[i], t_ra[i], t_rb[i], t_rd[i], t_da[i], ok);
      nvec++; if (!ok || im_wr !== 1'b1 || im_addr !== 7'(i) || im_wdata !== t_w[i] || cpu_hold !== 1'b1)
        begin nerr++; $display("FAIL dir_write%0d got=%b/%b/%0d/%h/%b exp=1/1/%0d/%h/1", i, ok, im_wr, im_addr, im_wdata, cpu_hold, i, t_w[i]); end
      tick();
    end
    nvec++; if (done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 8'd5 || in_ready !== 1'b0 || overflow !== 1'b0)
      begin nerr++; $display("FAIL dir_done got=%b/%b/%0d/%b/%b exp=1/0/5/0/0", done, cpu_hold, word_count, in_ready, overflow); end
  endtask

  task automatic test_stream(input int pairs);
    logic [15:0] exp_q[$];
    bit          exp_rdy;
    int          op, ra, rb, rd, da;
    wa_q.delete(); wd_q.delete();
    pulse_start();
    exp_rdy = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 2 * pairs; c++) begin
      op = $urandom_range(0, 4); ra = $urandom_range(0, 15); rb = $urandom_range(0, 15);
      rd = $urandom_range(0, 15); da = $urandom_range(0, 255);
      set_fields(op, ra, rb, rd, da);
      nvec++; if (in_ready !== exp_rdy) begin nerr++; $display("FAIL stream_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
      if (exp_rdy) exp_q.push_back(ref_word(op, ra, rb, rd, da));
      tick();
      nvec++; if (im_wr !== exp_rdy) begin nerr++; $display("FAIL stream_wr c=%0d got=%b exp=%b", c, im_wr, exp_rdy); end
      exp_rdy = !exp_rdy;
    end
    set_fields(5, $urandom_range(0, 15), 0, 0, 0);
    exp_q.push_back(16'h5000);
    tick();
    nvec++; if (im_wr !== 1'b1 || im_wdata !== 16'h5000) begin nerr++; $display("FAIL stream_halt got=%b/%h exp=1/5000", im_wr, im_wdata); end
    in_valid = 1'b0;
    tick();
    nvec++; if (done !== 1'b1 || word_count !== 8'(exp_q.size())) begin nerr++; $display("FAIL stream_done got=%b/%0d exp=1/%0d", done, word_count, exp_q.size()); end
    nvec++; if (wd_q.size() != exp_q.size()) begin nerr++; $display("FAIL stream_count got=%0d exp=%0d", wd_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wd_q.size(); i++) begin
      nvec++; if (wa_q[i] != i || wd_q[i] !== exp_q[i]) begin nerr++; $display("FAIL stream_word%0d got=%0d/%h exp=%0d/%h", i, wa_q[i], wd_q[i], i, exp_q[i]); end
    end
  endtask

  task automatic test_bad_op;
    bit ok;
    pulse_start();
    send(7, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255), ok);
    nvec++; if (!ok || im_wr !== 1'b1 || im_wdata !== 16'h0000 || bad_op !== 1'b1) begin nerr++; $display("FAIL bad_op7 got=%b/%b/%h/%b exp=1/1/0000/1", ok, im_wr, im_wdata, bad_op); end
    tick();
    pulse_start();
    nvec++; if (word_count !== 8'd1 || bad_op !== 1'b1 || in_ready !== 1'b1) begin nerr++; $display("FAIL start_ignored got=%0d/%b/%b exp=1/1/1", word_count, bad_op, in_ready); end
    send(6, 1, 2, 3, 4, ok);
    nvec++; if (!ok || im_addr !== 7'd1 || im_wdata !== 16'h0000) begin nerr++; $display("FAIL bad_op6 got=%b/%0d/%h exp=1/1/0000", ok, im_addr, im_wdata); end
    tick();
    send(5, 0, 0, 0, 0, ok);
    tick();
    nvec++; if (done !== 1'b1 || bad_op !== 1'b1 || word_count !== 8'd3) begin nerr++; $display("FAIL bad_sticky got=%b/%b/%0d exp=1/1/3", done, bad_op, word_count); end
    pulse_start();
    nvec++; if (done !== 1'b0 || cpu_hold !== 1'b1 || bad_op !== 1'b0 || word_count !== 8'd0 || in_ready !== 1'b1)
      begin nerr++; $display("FAIL restart got=%b/%b/%b/%0d/%b exp=0/1/0/0/1", done, cpu_hold, bad_op, word_count, in_ready); end
    send(5, 0, 0, 0, 0, ok);
    tick();
  endtask

  task automatic test_overflow;
    logic [15:0] exp_q[$];
    int ra, rb, rd;
    bit ok;
    swa_q.delete(); swd_q.delete();
    s_start = 1'b1; tick(); s_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ra = $urandom_range(0, 15); rb = $urandom_range(0, 15); rd = $urandom_range(0, 15);
      exp_q.push_back(ref_word(3, ra, rb, rd, 0));
      s_send(3, ra, rb, rd, 0, ok);
      nvec++; if (!ok || s_im_addr !== 3'(i) || s_im_wdata !== exp_q[i]) begin nerr++; $display("FAIL ovf_add%0d got=%b/%0d/%h exp=1/%0d/%h", i, ok, s_im_addr, s_im_wdata, i, exp_q[i]); end
      tick();
    end
    set_fields(3, 1, 1, 1, 0);
    s_in_valid = 1'b1;
    nvec++; if (s_in_ready !== 1'b0) begin nerr++; $display("FAIL ovf_ready got=%b exp=0", s_in_ready); end
    tick();
    exp_q.push_back(16'h5000);
    nvec++; if (s_im_wr !== 1'b1 || s_im_addr !== 3'd7 || s_im_wdata !== 16'h5000) begin nerr++; $display("FAIL ovf_halt got=%b/%0d/%h exp=1/7/5000", s_im_wr, s_im_addr, s_im_wdata); end
    tick();
    s_in_valid = 1'b0;
    nvec++; if (s_done !== 1'b1 || s_overflow !== 1'b1 || s_word_count !== 4'd8 || s_cpu_hold !== 1'b0)
      begin nerr++; $display("FAIL ovf_done got=%b/%b/%0d/%b exp=1/1/8/0", s_done, s_overflow, s_word_count, s_cpu_hold); end
    nvec++; if (swd_q.size() != 8) begin nerr++; $display("FAIL ovf_count got=%0d exp=8", swd_q.size()); end
    for (int i = 0; i < 8 && i < swd_q.size(); i++) begin
      nvec++; if (swa_q[i] != i || swd_q[i] !== exp_q[i]) begin nerr++; $display("FAIL ovf_word%0d got=%0d/%h exp=%0d/%h", i, swa_q[i], swd_q[i], i, exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream($urandom_range(5, 15));
    test_stream($urandom_range(5, 15));
    test_bad_op();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Program loader that sits between a host/test interface and the instruction memory.
- Accepts symbolic instruction fields over a valid/ready handshake and encodes them into 16-bit instruction words in the same format the controller decodes.
- Writes the words sequentially into instruction memory from address 0.
- Holds the processor in its Init state until loading completes.

Parameters:
- ADDR_W, 7, instruction memory address width. DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new load session. Honoured only in IDLE or DONE.
- in_valid  in  1  host presents an instruction.
- in_ready  out  1  loader can accept an instruction.
- in_op  in  3  0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT. Values 6 and 7 are illegal.
- in_ra  in  4  source register A (STORE, ADD, SUB).
- in_rb  in  4  source register B (ADD, SUB).
- in_rd  in  4  destination register (LOAD, ADD, SUB).
- in_daddr  in  8  data memory address (LOAD, STORE).
- im_wr  out  1  instruction memory write strobe.
- im_addr  out  ADDR_W  instruction memory write address.
- im_wdata  out  16  encoded instruction word.
- cpu_hold  out  1  high holds the processor controller in Init.
- done  out  1  load session complete.
- overflow  out  1  sticky; memory filled without a HALT.
- bad_op  out  1  sticky; an illegal in_op was received.
- word_count  out  ADDR_W+1  number of words written this session.

Behaviour:
- Reset (asynchronous, any state, including mid-session):
  - state = IDLE, ptr = 0, word_count = 0.
  - im_wr = 0, im_addr = 0, im_wdata = 0.
  - cpu_hold = 1, done = 0, in_ready = 0, overflow = 0, bad_op = 0.
- Encoding (opcode nibble = {1'b0, in_op}):
  - NOOP = 16'h0000.
  - STORE = {4'h1, ra, daddr}.
  - LOAD = {4'h2, daddr, rd}.
  - ADD = {4'h3, ra, rb, rd}.
  - SUB = {4'h4, ra, rb, rd}.
  - HALT = 16'h5000.
  - Illegal op: encode as NOOP and set bad_op.
- States:
  - IDLE: cpu_hold = 1, in_ready = 0.
    - start → ACCEPT. Clears ptr, word_count, overflow, bad_op.
  - ACCEPT: in_ready = 1 when ptr < DEPTH-1.
    - If ptr == DEPTH-1: in_ready = 0, the HALT word is loaded, overflow set, next state WRITE.
    - Otherwise, on in_valid & in_ready: register encoded word and HALT flag, next state WRITE.
    - in_valid without in_ready has no effect. Fields are sampled only on the handshake cycle.
  - WRITE: im_wr = 1 for exactly one cycle, with im_addr = ptr and im_wdata = the registered word.
    - ptr and word_count increment.
    - If the word is HALT → DONE, otherwise → ACCEPT.
  - DONE: cpu_hold = 0, done = 1, in_ready = 0.
    - start → ACCEPT. Clears counters and flags, reasserts cpu_hold, drops done the next cycle.
- Timing:
  - Handshake on cycle N → im_wr high on cycle N+1.
  - Maximum throughput is one word every 2 cycles.
  - im_wr, im_addr and im_wdata come directly from registers (no combinational path from inputs).
- start in ACCEPT or WRITE is ignored.
- DEPTH-1 is the last usable slot and always receives the final word, so a session always ends in HALT. word_count saturates at DEPTH.
- cpu_hold stays high throughout ACCEPT and WRITE.

Decomposition:
- Package isa_pkg:
  - Opcode localparams OP_NOOP..OP_HALT (4'h0..4'h5).
  - 3-bit op_t enum.
  - loader_state_t enum {IDLE, ACCEPT, WRITE, DONE}.
  - HALT_WORD constant.
- Sub-module instr_encoder: combinational fields → 16-bit word plus an illegal flag. It is reusable by the bench as a reference model.

Test Plan:
- Reset high mid-ACCEPT with ptr = 3 → same cycle: cpu_hold = 1, in_ready = 0, im_wr = 0. After release: state IDLE, word_count = 0.
- start, then ADD ra=5 rb=3 rd=6 → im_wr at addr 0 with data 16'h3536 one cycle after handshake. Then SUB 1,2,5 → addr 1, 16'h4125.
- LOAD daddr=8'h6A rd=4'hA → 16'h26AA. STORE ra=4'hA daddr=8'h6A → 16'h1A6A. HALT → 16'h5000, then done = 1, cpu_hold = 0, word_count = 5.
- in_valid held continuously with a new op every cycle → exactly one write per 2 cycles, in_ready toggles, no word dropped or duplicated.
- in_op = 7 → word 16'h0000 written, bad_op = 1 and stays set until next start.
- ADDR_W = 3, eight ADDs without HALT → addresses 0-6 hold ADDs, address 7 = 16'h5000, overflow = 1, done = 1, word_count = 8.
